id_ex_stage: RTL and testbench



---
 rtl/id_ex_stage_pkg.sv | 21 ++
 rtl/id_ex_stage_lu_hazard_detect.sv | 26 ++
 rtl/id_ex_stage.sv | 135 +++++++++++++
 tb/tb_id_ex_stage.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared types and macros for the ID/EX pipeline register.
`ifndef ID_EX_STAGE_DEFINES
`define ID_EX_STAGE_DEFINES
`define ZeroReg 5'b00000
`define AluOpW  5
`endif

package id_ex_stage_pkg;

    typedef logic [31:0] RegBus;
    typedef logic [4:0]  RegAddrBus;
    typedef logic [31:0] InstAddrBus;

    // EMPTY: no entry, FULL: valid entry, BUBBLE: invalid entry inserted by a load-use hazard
    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        FULL   = 2'd1,
        BUBBLE = 2'd2
    } id_ex_state_e;

endpackage

// File: rtl/id_ex_stage_lu_hazard_detect.sv
// Load-use hazard detection: an ID instruction reading the destination of a load still in EX.
module lu_hazard_detect
    import id_ex_stage_pkg::*;
(
    input  logic      id_valid,
    input  RegAddrBus id_rs1,
    input  RegAddrBus id_rs2,
    input  logic      id_use_rs1,
    input  logic      id_use_rs2,
    input  logic      ex_valid,
    input  logic      ex_is_load,
    input  RegAddrBus ex_rd,
    output logic      hz
);

    logic rs1_match;
    logic rs2_match;

    // x0 is never a real producer, so a load to x0 cannot create a dependency
    always_comb begin
        rs1_match = id_use_rs1 && (id_rs1 == ex_rd);
        rs2_match = id_use_rs2 && (id_rs2 == ex_rd);
        hz = id_valid && ex_valid && ex_is_load && (ex_rd != `ZeroReg) && (rs1_match || rs2_match);
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, EX back-pressure and branch flush.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int ALU_OP_W = `AluOpW,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    input  logic                id_valid_i,
    output logic                id_ready_o,
    input  InstAddrBus          id_pc_i,
    input  RegAddrBus           id_rs1_i,
    input  RegAddrBus           id_rs2_i,
    input  logic                id_use_rs1_i,
    input  logic                id_use_rs2_i,
    input  RegAddrBus           id_rd_i,
    input  logic                id_we_i,
    input  logic                id_is_load_i,
    input  logic [ALU_OP_W-1:0] id_alu_op_i,
    input  RegBus               id_imm_i,
    input  RegBus               fwd_data1_i,
    input  RegBus               fwd_data2_i,
    input  logic                ex_ready_i,
    output logic                ex_valid_o,
    output InstAddrBus          ex_pc_o,
    output RegBus               ex_op1_o,
    output RegBus               ex_op2_o,
    output RegBus               ex_imm_o,
    output RegAddrBus           ex_rd_o,
    output logic                ex_we_o,
    output logic                ex_is_load_o,
    output logic [ALU_OP_W-1:0] ex_alu_op_o,
    output logic                hazard_o,
    output logic [CNT_W-1:0]    lu_stall_cnt_o
);

    id_ex_state_e state;
    id_ex_state_e state_next;
    logic         hz;
    logic         adv;
    logic         do_bubble;
    logic         do_load;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    lu_hazard_detect u_lu_hazard_detect (
        .id_valid   (id_valid_i),
        .id_rs1     (id_rs1_i),
        .id_rs2     (id_rs2_i),
        .id_use_rs1 (id_use_rs1_i),
        .id_use_rs2 (id_use_rs2_i),
        .ex_valid   (ex_valid_o),
        .ex_is_load (ex_is_load_o),
        .ex_rd      (ex_rd_o),
        .hz         (hz)
    );

    // Handshake: the register may be overwritten when EX consumes it or it holds nothing
    always_comb begin
        adv        = ex_ready_i || !ex_valid_o;
        do_bubble  = !flush_i && hz && adv;
        do_load    = !flush_i && adv && id_valid_i && !hz;
        hazard_o   = hz;
        id_ready_o = flush_i || (adv && !hz);
    end

    // Next-state selection in flush > bubble > load > drain > hold priority
    always_comb begin
        state_next = state;
        if (flush_i) begin
            state_next = EMPTY;
        end else if (hz && adv) begin
            state_next = BUBBLE;
        end else if (adv && id_valid_i) begin
            state_next = FULL;
        end else if (adv) begin
            state_next = EMPTY;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Pipeline register: invalid entries also clear we/is_load so nothing downstream sees a stale write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_o   <= 1'b0;
            ex_pc_o      <= '0;
            ex_op1_o     <= '0;
            ex_op2_o     <= '0;
            ex_imm_o     <= '0;
            ex_rd_o      <= `ZeroReg;
            ex_we_o      <= 1'b0;
            ex_is_load_o <= 1'b0;
            ex_alu_op_o  <= '0;
        end else if (do_load) begin
            ex_valid_o   <= 1'b1;
            ex_pc_o      <= id_pc_i;
            ex_op1_o     <= fwd_data1_i;
            ex_op2_o     <= fwd_data2_i;
            ex_imm_o     <= id_imm_i;
            ex_rd_o      <= id_rd_i;
            ex_we_o      <= id_we_i;
            ex_is_load_o <= id_is_load_i;
            ex_alu_op_o  <= id_alu_op_i;
        end else if (flush_i || adv) begin
            ex_valid_o   <= 1'b0;
            ex_we_o      <= 1'b0;
            ex_is_load_o <= 1'b0;
        end
    end

    // Saturating count of inserted load-use bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_stall_cnt_o <= '0;
        end else if (do_bubble) begin
            lu_stall_cnt_o <= sat_inc(lu_stall_cnt_o);
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage.
module tb_id_ex_stage;
    import id_ex_stage_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    InstAddrBus  id_pc;
    RegAddrBus   id_rs1, id_rs2, id_rd;
    logic        id_use_rs1, id_use_rs2, id_we, id_is_load;
    logic [4:0]  id_alu_op;
    RegBus       id_imm, fwd1, fwd2;
    logic        ex_ready;
    logic        ex_valid;
    InstAddrBus  ex_pc;
    RegBus       ex_op1, ex_op2, ex_imm;
    RegAddrBus   ex_rd;
    logic        ex_we, ex_is_load;
    logic [4:0]  ex_alu_op;
    logic        hazard;
    logic [15:0] cnt;

    logic        id_ready2, ex_valid2, ex_we2, ex_is_load2, hazard2;
    InstAddrBus  ex_pc2;
    RegBus       ex_op1_2, ex_op2_2, ex_imm2;
    RegAddrBus   ex_rd2;
    logic [4:0]  ex_alu_op2;
    logic [1:0]  cnt2;

    int checks = 0;
    int errors = 0;

    id_ex_stage #(.ALU_OP_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .id_valid_i(id_valid), .id_ready_o(id_ready),
        .id_pc_i(id_pc), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_use_rs1_i(id_use_rs1),
        .id_use_rs2_i(id_use_rs2), .id_rd_i(id_rd), .id_we_i(id_we), .id_is_load_i(id_is_load),
        .id_alu_op_i(id_alu_op), .id_imm_i(id_imm), .fwd_data1_i(fwd1), .fwd_data2_i(fwd2),
        .ex_ready_i(ex_ready), .ex_valid_o(ex_valid), .ex_pc_o(ex_pc), .ex_op1_o(ex_op1),
        .ex_op2_o(ex_op2), .ex_imm_o(ex_imm), .ex_rd_o(ex_rd), .ex_we_o(ex_we),
        .ex_is_load_o(ex_is_load), .ex_alu_op_o(ex_alu_op), .hazard_o(hazard), .lu_stall_cnt_o(cnt)
    );

    id_ex_stage #(.ALU_OP_W(5), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush_i(flush), .id_valid_i(id_valid), .id_ready_o(id_ready2),
        .id_pc_i(id_pc), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_use_rs1_i(id_use_rs1),
        .id_use_rs2_i(id_use_rs2), .id_rd_i(id_rd), .id_we_i(id_we), .id_is_load_i(id_is_load),
        .id_alu_op_i(id_alu_op), .id_imm_i(id_imm), .fwd_data1_i(fwd1), .fwd_data2_i(fwd2),
        .ex_ready_i(ex_ready), .ex_valid_o(ex_valid2), .ex_pc_o(ex_pc2), .ex_op1_o(ex_op1_2),
        .ex_op2_o(ex_op2_2), .ex_imm_o(ex_imm2), .ex_rd_o(ex_rd2), .ex_we_o(ex_we2),
        .ex_is_load_o(ex_is_load2), .ex_alu_op_o(ex_alu_op2), .hazard_o(hazard2), .lu_stall_cnt_o(cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one ID instruction (or idle when v=0); everything else defaults to a plain ALU op
    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                         input logic ld, input logic [4:0] rs1, input logic u1,
                         input logic [4:0] rs2, input logic u2, input logic [31:0] d1);
        flush      = 1'b0;
        id_valid   = v;
        id_pc      = pc;
        id_rd      = rd;
        id_we      = 1'b1;
        id_is_load = ld;
        id_rs1     = rs1;
        id_use_rs1 = u1;
        id_rs2     = rs2;
        id_use_rs2 = u2;
        id_alu_op  = 5'd3;
        id_imm     = 32'h0000_0ABC;
        fwd1       = d1;
        fwd2       = 32'h22;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ex_ready = 1'b1;
        drive(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
        #12;
        checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", ex_valid); end
        checks++; if (ex_rd !== 5'd0 || ex_pc !== 32'h0 || ex_op1 !== 32'h0) begin errors++; $display("FAIL reset_fields rd=%0d pc=%h op1=%h exp=0", ex_rd, ex_pc, ex_op1); end
        checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL reset_id_ready got=%0b exp=1", id_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        ex_ready = 1'b1;
        drive(1'b1, 32'h0, 5'd1, 1'b0, 5'd2, 1'b1, 5'd3, 1'b1, 32'h11);
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%0b exp=1", id_ready); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_op1 !== 32'h11 || ex_pc !== 32'h0) begin errors++; $display("FAIL b2b_0 valid=%0b op1=%h pc=%h exp 1/11/0", ex_valid, ex_op1, ex_pc); end
        checks++; if (ex_imm !== 32'hABC || ex_op2 !== 32'h22 || ex_rd !== 5'd1 || ex_alu_op !== 5'd3 || ex_we !== 1'b1) begin errors++; $display("FAIL b2b_fields imm=%h op2=%h rd=%0d op=%0d we=%0b", ex_imm, ex_op2, ex_rd, ex_alu_op, ex_we); end
        drive(1'b1, 32'h4, 5'd1, 1'b0, 5'd2, 1'b1, 5'd3, 1'b1, 32'h12);
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_op1 !== 32'h12 || ex_pc !== 32'h4) begin errors++; $display("FAIL b2b_4 valid=%0b op1=%h pc=%h exp 1/12/4", ex_valid, ex_op1, ex_pc); end
        drive(1'b1, 32'h8, 5'd1, 1'b0, 5'd2, 1'b1, 5'd3, 1'b1, 32'h13);
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_op1 !== 32'h13 || ex_pc !== 32'h8) begin errors++; $display("FAIL b2b_8 valid=%0b op1=%h pc=%h exp 1/13/8", ex_valid, ex_op1, ex_pc); end
        checks++; if (cnt !== 16'd0) begin errors++; $display("FAIL b2b_cnt got=%0d exp=0", cnt); end
    endtask

    task automatic test_load_use();
        ex_ready = 1'b1;
        drive(1'b1, 32'h10, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 32'h14, 5'd6, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 32'hBAD);
        #1;
        checks++; if (hazard !== 1'b1 || id_ready !== 1'b0) begin errors++; $display("FAIL lu_detect hazard=%0b ready=%0b exp 1/0", hazard, id_ready); end
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_we !== 1'b0 || ex_is_load !== 1'b0) begin errors++; $display("FAIL lu_bubble valid=%0b we=%0b ld=%0b exp 0/0/0", ex_valid, ex_we, ex_is_load); end
        checks++; if (dut.state !== BUBBLE) begin errors++; $display("FAIL lu_state got=%0d exp=%0d", dut.state, BUBBLE); end
        checks++; if (cnt !== 16'd1) begin errors++; $display("FAIL lu_cnt got=%0d exp=1", cnt); end
        fwd1 = 32'hDEAD;
        #1;
        checks++; if (hazard !== 1'b0 || id_ready !== 1'b1) begin errors++; $display("FAIL lu_after hazard=%0b ready=%0b exp 0/1", hazard, id_ready); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_op1 !== 32'hDEAD || ex_pc !== 32'h14 || ex_rd !== 5'd6) begin errors++; $display("FAIL lu_load valid=%0b op1=%h pc=%h rd=%0d exp 1/dead/14/6", ex_valid, ex_op1, ex_pc, ex_rd); end
    endtask

    task automatic test_no_hazard();
        ex_ready = 1'b1;
        drive(1'b1, 32'h20, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
        tick();
        // load to x7 reading x0: must not stall behind the x0 load
        drive(1'b1, 32'h24, 5'd7, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 32'h1);
        #1;
        checks++; if (hazard !== 1'b0 || id_ready !== 1'b1) begin errors++; $display("FAIL nohz_x0 hazard=%0b ready=%0b exp 0/1", hazard, id_ready); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h24 || ex_is_load !== 1'b1) begin errors++; $display("FAIL nohz_x0_load valid=%0b pc=%h ld=%0b exp 1/24/1", ex_valid, ex_pc, ex_is_load); end
        drive(1'b1, 32'h28, 5'd8, 1'b0, 5'd1, 1'b1, 5'd7, 1'b0, 32'h2);
        #1;
        checks++; if (hazard !== 1'b0 || id_ready !== 1'b1) begin errors++; $display("FAIL nohz_unused hazard=%0b ready=%0b exp 0/1", hazard, id_ready); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h28 || cnt !== 16'd1) begin errors++; $display("FAIL nohz_unused_load valid=%0b pc=%h cnt=%0d exp 1/28/1", ex_valid, ex_pc, cnt); end
    endtask

    task automatic test_back_pressure();
        ex_ready = 1'b1;
        drive(1'b1, 32'h40, 5'd9, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 32'h100);
        tick();
        ex_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h44, 5'd10, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 32'h200 + i);
            fwd2 = 32'h300 + i;
            #1;
            checks++; if (id_ready !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d] got=%0b exp=0", i, id_ready); end
            tick();
            checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h40 || ex_op1 !== 32'h100 || ex_op2 !== 32'h22 || ex_rd !== 5'd9) begin errors++; $display("FAIL bp_hold[%0d] valid=%0b pc=%h op1=%h op2=%h rd=%0d exp 1/40/100/22/9", i, ex_valid, ex_pc, ex_op1, ex_op2, ex_rd); end
        end
        ex_ready = 1'b1;
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%0b exp=1", id_ready); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h44 || ex_op1 !== 32'h202 || ex_op2 !== 32'h302) begin errors++; $display("FAIL bp_release valid=%0b pc=%h op1=%h op2=%h exp 1/44/202/302", ex_valid, ex_pc, ex_op1, ex_op2); end
    endtask

    task automatic test_flush();
        ex_ready = 1'b0;
        drive(1'b1, 32'h48, 5'd11, 1'b0, 5'd1, 1'b1, 5'd2, 1'b1, 32'h5);
        flush = 1'b1;
        #1;
        checks++; if (id_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%0b exp=1", id_ready); end
        tick();
        checks++; if (ex_valid !== 1'b0 || ex_we !== 1'b0) begin errors++; $display("FAIL flush_kill valid=%0b we=%0b exp 0/0", ex_valid, ex_we); end
        checks++; if (dut.state !== EMPTY) begin errors++; $display("FAIL flush_state got=%0d exp=%0d", dut.state, EMPTY); end
        flush = 1'b0;
        ex_ready = 1'b1;
    endtask

    task automatic test_stalled_hazard();
        ex_ready = 1'b1;
        drive(1'b1, 32'h50, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
        tick();
        ex_ready = 1'b0;
        drive(1'b1, 32'h54, 5'd12, 1'b0, 5'd3, 1'b0, 5'd5, 1'b1, 32'h7);
        #1;
        checks++; if (hazard !== 1'b1 || id_ready !== 1'b0) begin errors++; $display("FAIL stall_hz hazard=%0b ready=%0b exp 1/0", hazard, id_ready); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h50 || cnt !== 16'd1 || dut.state !== FULL) begin errors++; $display("FAIL stall_hold valid=%0b pc=%h cnt=%0d state=%0d exp 1/50/1/FULL", ex_valid, ex_pc, cnt, dut.state); end
        ex_ready = 1'b1;
        tick();
        checks++; if (ex_valid !== 1'b0 || cnt !== 16'd2) begin errors++; $display("FAIL stall_bubble valid=%0b cnt=%0d exp 0/2", ex_valid, cnt); end
        tick();
        checks++; if (ex_valid !== 1'b1 || ex_pc !== 32'h54 || ex_op1 !== 32'h7) begin errors++; $display("FAIL stall_load valid=%0b pc=%h op1=%h exp 1/54/7", ex_valid, ex_pc, ex_op1); end
    endtask

    task automatic test_saturation();
        ex_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h60, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
            tick();
            drive(1'b1, 32'h64, 5'd13, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 32'h9);
            tick();
        end
        checks++; if (cnt !== 16'd5) begin errors++; $display("FAIL sat_cnt16 got=%0d exp=5", cnt); end
        checks++; if (cnt2 !== 2'd3) begin errors++; $display("FAIL sat_cnt2 got=%0d exp=3", cnt2); end
    endtask

    task automatic test_reset_mid_hazard();
        ex_ready = 1'b1;
        drive(1'b1, 32'h70, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
        tick();
        drive(1'b1, 32'h74, 5'd14, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 32'h3);
        #1;
        checks++; if (hazard !== 1'b1 || dut.state !== FULL) begin errors++; $display("FAIL rst_pre hazard=%0b state=%0d exp 1/FULL", hazard, dut.state); end
        rst_n = 1'b0;
        #1;
        checks++; if (ex_valid !== 1'b0 || cnt !== 16'd0 || cnt2 !== 2'd0 || ex_rd !== 5'd0 || ex_valid2 !== 1'b0) begin errors++; $display("FAIL rst_async valid=%0b cnt=%0d cnt2=%0d rd=%0d exp 0/0/0/0", ex_valid, cnt, cnt2, ex_rd); end
        drive(1'b0, 32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (dut.state !== EMPTY || ex_valid !== 1'b0) begin errors++; $display("FAIL rst_release state=%0d valid=%0b exp EMPTY/0", dut.state, ex_valid); end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_load_use();
        test_no_hazard();
        test_back_pressure();
        test_flush();
        test_stalled_hazard();
        test_saturation();
        test_reset_mid_hazard();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
